puf_ctrl: RTL and testbench
===========================

PUF_CTRL -- requirements
Module: puf_ctrl

Interface
REQ-001 Parameter CHAL_W, default 32: challenge width in bits, minimum 2.
REQ-002 Parameter RESP_W, default 32: response width in bits, minimum 2.
REQ-003 Parameter EVAL_CYCLES, default 16: settle cycles after the PUF reset pulse, minimum 1.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to begin one challenge/response transaction.
REQ-007 abort  input  1  synchronous cancel of the transaction in flight.
REQ-008 sel_in  input  2  PUF instance select for the transaction.
REQ-009 length_in  input  2  PUF length code for the transaction.
REQ-010 challenge  input  CHAL_W  challenge word.
REQ-011 puf_out  input  1  PUF evaluation output.
REQ-012 puf_so  input  1  PUF scan-out bit.
REQ-013 puf_reset  output  1  PUF reset, active-high.
REQ-014 puf_sel  output  2  registered PUF select.
REQ-015 puf_length  output  2  registered PUF length code.
REQ-016 puf_si  output  1  PUF scan-in bit.
REQ-017 busy  output  1  high whenever the FSM is not in IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 response  output  RESP_W  captured response; held stable until the next done.
REQ-020 out_bit  output  1  puf_out value sampled in the last EVAL cycle of the final pass.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, LOAD, EVAL, READ and DONE; every output SHALL be registered.
REQ-022 In IDLE, start=1 SHALL latch challenge, sel_in and length_in, drive puf_sel and puf_length from the latched values, and move to LOAD on the next edge.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 LOAD SHALL last exactly CHAL_W cycles and drive puf_si with challenge bit CHAL_W-1-k in LOAD cycle k (MSB first).
REQ-025 EVAL SHALL last 1+EVAL_CYCLES cycles, with puf_reset=1 in the first cycle only and puf_si=0 throughout.
REQ-026 READ SHALL last exactly RESP_W cycles; in each cycle puf_so SHALL be shifted into the LSB of a response shift register (first bit sampled ends at the MSB).
REQ-027 DONE SHALL last one cycle: response and out_bit SHALL update and done=1, then the FSM SHALL return to IDLE.
REQ-028 Single-pass latency, counted from the start edge to the done=1 cycle, SHALL be 1+CHAL_W+1+EVAL_CYCLES+RESP_W cycles.
REQ-029 One counter of width clog2(max(CHAL_W,RESP_W,EVAL_CYCLES+1)) SHALL time all phases and SHALL reload to 0 on every state change.
REQ-030 abort=1 in LOAD, EVAL or READ SHALL return the FSM to IDLE on the next edge with puf_si=0, puf_reset=0, no done pulse, and response and out_bit unchanged.
REQ-031 abort=1 in the same cycle as start in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-032 abort=1 in IDLE or DONE SHALL have no effect.

Reset
REQ-033 rstn=0 SHALL immediately force: state=IDLE, counter=0, busy=0, done=0, puf_reset=1, puf_si=0, puf_sel=0, puf_length=0, response=0, out_bit=0.
REQ-034 puf_reset SHALL deassert on the first clk edge after rstn rises.
REQ-035 rstn=0 mid-transaction SHALL discard the transaction; no done SHALL follow.

Configuration
REQ-036 Macro PUF_CTRL_MAJORITY_EN defined: each transaction SHALL run the LOAD→EVAL→READ sequence 3 times back-to-back, and response SHALL be the bitwise majority of the 3 captured words.
REQ-037 With PUF_CTRL_MAJORITY_EN defined, latency SHALL be 1+3*(CHAL_W+1+EVAL_CYCLES+RESP_W) cycles, and abort SHALL cancel all remaining passes.
REQ-038 Macro PUF_CTRL_MAJORITY_EN undefined: the block SHALL run a single pass and SHALL contain no majority storage.

Verification (CHAL_W=8, RESP_W=8, EVAL_CYCLES=4)
REQ-039 challenge=0xA5, sel_in=2, length_in=1, start pulse -> puf_si sequence 1,0,1,0,0,1,0,1; puf_sel=2; puf_length=1; one puf_reset cycle; done exactly 22 cycles after start.
REQ-040 puf_so drives 1,1,0,0,1,0,1,1 during READ -> response=0xCB at done; out_bit equals puf_out sampled in the last EVAL cycle.
REQ-041 start re-pulsed in LOAD, EVAL and READ -> ignored; exactly one done; latched challenge not overwritten.
REQ-042 abort in READ cycle 3 -> IDLE next cycle; no done; response keeps its previous value; a new start completes normally.
REQ-043 rstn low during EVAL -> all outputs at reset values asynchronously; puf_reset=1 until the first edge after release; no done.
REQ-044 PUF_CTRL_MAJORITY_EN defined, passes return 0xF0, 0xCC, 0xAA -> response=0xE8; done after 64 cycles.

Source files
------------

// File: rtl/puf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : puf_ctrl
// Brief   : Challenge/response sequencer for a scan-loaded PUF (LOAD, EVAL, READ).
// Option  : PUF_CTRL_MAJORITY_EN - three passes per request, bitwise-majority response
// Rev     : 1.0
// ============================================================================
module puf_ctrl #(
   parameter int CHAL_W      = 32,
   parameter int RESP_W      = 32,
   parameter int EVAL_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   input  logic [1:0]        sel_in,
   input  logic [1:0]        length_in,
   input  logic [CHAL_W-1:0] challenge,
   input  logic              puf_out,
   input  logic              puf_so,
   output logic              puf_reset,
   output logic [1:0]        puf_sel,
   output logic [1:0]        puf_length,
   output logic              puf_si,
   output logic              busy,
   output logic              done,
   output logic [RESP_W-1:0] response,
   output logic              out_bit
);

   localparam int CNT_MAX_A = (CHAL_W > RESP_W) ? CHAL_W : RESP_W;
   localparam int CNT_MAX   = (CNT_MAX_A > EVAL_CYCLES + 1) ? CNT_MAX_A : EVAL_CYCLES + 1;
   localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(CHAL_W - 1);
   localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(EVAL_CYCLES);
   localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(RESP_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_EVAL = 3'd2,
      S_READ = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CHAL_W-1:0]   chal_q;
   logic [RESP_W-1:0]   sh_q;
   logic                eval_bit_q;
   logic                puf_reset_q;
   logic [1:0]          puf_sel_q;
   logic [1:0]          puf_length_q;
   logic                puf_si_q;
   logic                busy_q;
   logic                done_q;
   logic [RESP_W-1:0]   response_q;
   logic                out_bit_q;

   logic [RESP_W-1:0]   w_sh_next;
   logic [RESP_W-1:0]   w_final;
   logic                w_more_pass;
   logic [CHAL_W-1:0]   w_chal_rot;

   assign w_sh_next  = {sh_q[RESP_W-2:0], puf_so};
   // chal_q is rotated once per bit sent, so it is back to the original word after each LOAD
   assign w_chal_rot = {chal_q[CHAL_W-2:0], chal_q[CHAL_W-1]};

`ifdef PUF_CTRL_MAJORITY_EN
   logic [1:0]          pass_q;
   logic [RESP_W-1:0]   word0_q;
   logic [RESP_W-1:0]   word1_q;

   assign w_final     = (word0_q & word1_q) | (word0_q & w_sh_next) | (word1_q & w_sh_next);
   assign w_more_pass = (pass_q != 2'd2);
`else
   assign w_final     = w_sh_next;
   assign w_more_pass = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         chal_q       <= '0;
         sh_q         <= '0;
         eval_bit_q   <= 1'b0;
         puf_reset_q  <= 1'b1;
         puf_sel_q    <= 2'd0;
         puf_length_q <= 2'd0;
         puf_si_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         response_q   <= '0;
         out_bit_q    <= 1'b0;
`ifdef PUF_CTRL_MAJORITY_EN
         pass_q       <= 2'd0;
         word0_q      <= '0;
         word1_q      <= '0;
`endif
      end else begin
         puf_reset_q <= 1'b0;
         done_q      <= 1'b0;
         if (abort && (state_q == S_LOAD || state_q == S_EVAL || state_q == S_READ)) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            puf_si_q <= 1'b0;
            busy_q   <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start && !abort) begin
                     chal_q       <= {challenge[CHAL_W-2:0], challenge[CHAL_W-1]};
                     puf_si_q     <= challenge[CHAL_W-1];
                     puf_sel_q    <= sel_in;
                     puf_length_q <= length_in;
                     busy_q       <= 1'b1;
                     cnt_q        <= '0;
                     state_q      <= S_LOAD;
`ifdef PUF_CTRL_MAJORITY_EN
                     pass_q       <= 2'd0;
`endif
                  end
               end
               S_LOAD: begin
                  if (cnt_q == LOAD_LAST) begin
                     cnt_q       <= '0;
                     puf_reset_q <= 1'b1;
                     puf_si_q    <= 1'b0;
                     state_q     <= S_EVAL;
                  end else begin
                     cnt_q    <= cnt_q + CNT_ONE;
                     puf_si_q <= chal_q[CHAL_W-1];
                     chal_q   <= w_chal_rot;
                  end
               end
               S_EVAL: begin
                  if (cnt_q == EVAL_LAST) begin
                     eval_bit_q <= puf_out;
                     cnt_q      <= '0;
                     state_q    <= S_READ;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_READ: begin
                  sh_q <= w_sh_next;
                  if (cnt_q == READ_LAST) begin
                     cnt_q <= '0;
                     if (w_more_pass) begin
`ifdef PUF_CTRL_MAJORITY_EN
                        if (pass_q == 2'd0) word0_q <= w_sh_next;
                        else                word1_q <= w_sh_next;
                        pass_q <= pass_q + 2'd1;
`endif
                        puf_si_q <= chal_q[CHAL_W-1];
                        chal_q   <= w_chal_rot;
                        state_q  <= S_LOAD;
                     end else begin
                        response_q <= w_final;
                        out_bit_q  <= eval_bit_q;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               S_DONE: begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: begin
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign puf_reset  = puf_reset_q;
   assign puf_sel    = puf_sel_q;
   assign puf_length = puf_length_q;
   assign puf_si     = puf_si_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign response   = response_q;
   assign out_bit    = out_bit_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_puf_ctrl
// Brief   : Scoreboard bench for puf_ctrl (CHAL_W=8, RESP_W=8, EVAL_CYCLES=4).
// Option  : PUF_CTRL_MAJORITY_EN - selects three-pass expectations
// Rev     : 1.0
// ============================================================================
module tb_puf_ctrl;

   localparam int CW = 8;
   localparam int RW = 8;
   localparam int EC = 4;
`ifdef PUF_CTRL_MAJORITY_EN
   localparam int NP = 3;
`else
   localparam int NP = 1;
`endif
   localparam int PASS_LEN = CW + 1 + EC + RW;
   localparam int LAST_R   = 1 + NP * PASS_LEN;

   logic          clk;
   logic          rstn;
   logic          start;
   logic          abort;
   logic [1:0]    sel_in;
   logic [1:0]    length_in;
   logic [CW-1:0] challenge;
   logic          puf_out;
   logic          puf_so;
   logic          puf_reset;
   logic [1:0]    puf_sel;
   logic [1:0]    puf_length;
   logic          puf_si;
   logic          busy;
   logic          done;
   logic [RW-1:0] response;
   logic          out_bit;

   puf_ctrl #(.CHAL_W(CW), .RESP_W(RW), .EVAL_CYCLES(EC)) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .abort      (abort),
      .sel_in     (sel_in),
      .length_in  (length_in),
      .challenge  (challenge),
      .puf_out    (puf_out),
      .puf_so     (puf_so),
      .puf_reset  (puf_reset),
      .puf_sel    (puf_sel),
      .puf_length (puf_length),
      .puf_si     (puf_si),
      .busy       (busy),
      .done       (done),
      .response   (response),
      .out_bit    (out_bit)
   );

   typedef struct {
      logic [RW-1:0] resp;
      logic          obit;
      int            cyc;
   } exp_t;

   exp_t sbq[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passed = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
   endtask

   // Monitor: every done pulse is matched against the oldest outstanding expectation
   always @(negedge clk) begin
      if (rstn === 1'b1 && done === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("response", 32'(response), 32'(e.resp));
            chk("out_bit", 32'(out_bit), 32'(e.obit));
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic run_txn(input logic [CW-1:0] ch, input logic [1:0] sl, input logic [1:0] ln,
                          input logic [RW-1:0] wa, input logic [RW-1:0] wb, input logic [RW-1:0] wc,
                          input logic [RW-1:0] exp_resp, input logic obit,
                          input int abort_r, input int rst_r, input bit restart);
      logic [RW-1:0] words [3];
      logic [RW-1:0] prev_resp;
      int t0;
      int p;
      int q;
      exp_t e;
      words[0] = wa; words[1] = wb; words[2] = wc;
      @(posedge clk); #1;
      prev_resp = response;
      challenge = ch; sel_in = sl; length_in = ln; start = 1'b1; abort = 1'b0;
      t0 = cyc;
      if (abort_r == 0 && rst_r == 0) begin
         e.resp = exp_resp; e.obit = obit; e.cyc = t0 + LAST_R;
         sbq.push_back(e);
      end
      for (int r = 1; r <= LAST_R; r++) begin
         @(posedge clk); #1;
         p = (r - 1) / PASS_LEN;
         q = (r - 1) % PASS_LEN + 1;
         challenge = ~ch; sel_in = ~sl; length_in = ~ln;
         start = restart && (r == 3 || r == 11 || r == 16);
         abort = (r == abort_r);
         puf_out = (r == LAST_R - 9) ? obit : ~obit;
         puf_so = (r < LAST_R && q >= CW + EC + 2) ? words[p][3'(RW - 1 - (q - (CW + EC + 2)))] : 1'b1;
         if (r == rst_r) begin
            start = 1'b0; abort = 1'b0;
            rstn = 1'b0;
            #1;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_puf_reset", 32'(puf_reset), 1);
            chk("rst_puf_si", 32'(puf_si), 0);
            chk("rst_puf_sel", 32'(puf_sel), 0);
            chk("rst_puf_length", 32'(puf_length), 0);
            chk("rst_response", 32'(response), 0);
            chk("rst_out_bit", 32'(out_bit), 0);
            @(posedge clk); #1;
            rstn = 1'b1;
            @(negedge clk);
            chk("rel_puf_reset_hold", 32'(puf_reset), 1);
            @(negedge clk);
            chk("rel_puf_reset_drop", 32'(puf_reset), 0);
            chk("rel_busy", 32'(busy), 0);
            return;
         end
         @(negedge clk);
         if (abort_r > 0 && r == abort_r + 1) begin
            chk("abort_busy", 32'(busy), 0);
            chk("abort_puf_si", 32'(puf_si), 0);
            chk("abort_puf_reset", 32'(puf_reset), 0);
            chk("abort_response_kept", 32'(response), 32'(prev_resp));
            start = 1'b0;
            return;
         end
         if (p == 0 && q <= CW) chk("puf_si_load", 32'(puf_si), 32'(ch[3'(CW - q)]));
         if (r == 1) begin
            chk("puf_sel", 32'(puf_sel), 32'(sl));
            chk("puf_length", 32'(puf_length), 32'(ln));
            chk("busy_load", 32'(busy), 1);
         end
         if (p == 0 && q == CW + 1) begin
            chk("puf_reset_eval0", 32'(puf_reset), 1);
            chk("puf_si_eval0", 32'(puf_si), 0);
         end
         if (p == 0 && q == CW + 2) chk("puf_reset_eval1", 32'(puf_reset), 0);
      end
      start = 1'b0; abort = 1'b0;
   endtask

   initial begin
      rstn = 1'b1; start = 1'b0; abort = 1'b0; sel_in = 2'd0; length_in = 2'd0;
      challenge = '0; puf_out = 1'b0; puf_so = 1'b0;
      #3 rstn = 1'b0;
      #1;
      chk("init_busy", 32'(busy), 0);
      chk("init_done", 32'(done), 0);
      chk("init_puf_reset", 32'(puf_reset), 1);
      chk("init_puf_si", 32'(puf_si), 0);
      chk("init_puf_sel", 32'(puf_sel), 0);
      chk("init_response", 32'(response), 0);
      chk("init_out_bit", 32'(out_bit), 0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("init_puf_reset_hold", 32'(puf_reset), 1);
      @(negedge clk);
      chk("init_puf_reset_drop", 32'(puf_reset), 0);

      // Basic transaction: A5 challenge, CB response
      run_txn(8'hA5, 2'd2, 2'd1, 8'hCB, 8'hCB, 8'hCB, 8'hCB, 1'b1, 0, 0, 1'b0);
      // start re-pulsed in LOAD, EVAL and READ must be ignored
      run_txn(8'h3C, 2'd1, 2'd3, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0, 0, 0, 1'b1);

      // abort together with start in IDLE: stays idle, latched select untouched
      @(posedge clk); #1;
      challenge = 8'hFF; sel_in = 2'd3; length_in = 2'd0; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("start_abort_busy", 32'(busy), 0);
      chk("start_abort_sel", 32'(puf_sel), 1);

      // abort in READ cycle 3, then a normal transaction
      run_txn(8'h5A, 2'd3, 2'd2, 8'h96, 8'h96, 8'h96, 8'h96, 1'b1, CW + EC + 5, 0, 1'b0);
      run_txn(8'hC3, 2'd0, 2'd0, 8'h69, 8'h69, 8'h69, 8'h69, 1'b0, 0, 0, 1'b0);

      // reset asserted during EVAL
      run_txn(8'hA5, 2'd2, 2'd1, 8'hCB, 8'hCB, 8'hCB, 8'hCB, 1'b1, 0, CW + 3, 1'b0);

`ifdef PUF_CTRL_MAJORITY_EN
      run_txn(8'hA5, 2'd2, 2'd1, 8'hF0, 8'hCC, 8'hAA, 8'hE8, 1'b1, 0, 0, 1'b0);
`else
      run_txn(8'h81, 2'd1, 2'd2, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 1'b0, 0, 0, 1'b0);
`endif

      repeat (5) @(posedge clk);
      if (sbq.size() != 0) begin
         checks++;
         $display("FAIL missing_done actual=0 required=%0d", sbq.size());
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
